sad_min_tracker: RTL and testbench

//   Consumes the stream of (SAD, row, col) candidate triples from the SAD array and keeps the running

---
 rtl/vbsme_pkg.sv | 13 +
 rtl/sad_compare_select.sv | 22 ++
 rtl/sad_min_tracker.sv | 92 +++++++++
 tb/tb_sad_min_tracker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vbsme_pkg.sv
// Shared widths, sizes and FSM encoding for the block-matching motion search.
package vbsme_pkg;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] SAD_MAX = '1;
    localparam int NUM_CAND = 3721;
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sad_compare_select.sv
// Strict-less SAD compare and 3-word select between candidate and stored best.
module sad_compare_select #(
    parameter int DATA_W = vbsme_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] i_cand_sad,
    input  logic [DATA_W-1:0] i_cand_row,
    input  logic [DATA_W-1:0] i_cand_col,
    input  logic [DATA_W-1:0] i_best_sad,
    input  logic [DATA_W-1:0] i_best_row,
    input  logic [DATA_W-1:0] i_best_col,
    output logic [DATA_W-1:0] o_next_sad,
    output logic [DATA_W-1:0] o_next_row,
    output logic [DATA_W-1:0] o_next_col
);
    logic w_take;

    // Strict compare: on a tie the earlier (stored) candidate wins.
    assign w_take     = (i_cand_sad < i_best_sad);
    assign o_next_sad = w_take ? i_cand_sad : i_best_sad;
    assign o_next_row = w_take ? i_cand_row : i_best_row;
    assign o_next_col = w_take ? i_cand_col : i_best_col;
endmodule

// File: rtl/sad_min_tracker.sv
// Running-minimum tracker over one search window of (SAD, row, col) candidates.
// state | meaning: IDLE = no window yet; RUN = accepting candidates; DONE = Best* final.
module sad_min_tracker #(
    parameter int DATA_W   = vbsme_pkg::DATA_W,
    parameter int NUM_CAND = vbsme_pkg::NUM_CAND,
    parameter int CNT_W    = vbsme_pkg::CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_cand_valid,
    output logic              o_cand_ready,
    input  logic [DATA_W-1:0] i_cand_sad,
    input  logic [DATA_W-1:0] i_cand_row,
    input  logic [DATA_W-1:0] i_cand_col,
    output logic [DATA_W-1:0] o_best_sad,
    output logic [DATA_W-1:0] o_best_row,
    output logic [DATA_W-1:0] o_best_col,
    output logic              o_busy,
    output logic              o_done
);
    import vbsme_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CAND - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_best_sad;
    logic [DATA_W-1:0] r_best_row;
    logic [DATA_W-1:0] r_best_col;
    logic [DATA_W-1:0] w_next_sad;
    logic [DATA_W-1:0] w_next_row;
    logic [DATA_W-1:0] w_next_col;
    logic              w_accept;
    logic              w_begin;

    assign o_cand_ready = (r_state == RUN);
    assign o_busy       = (r_state == RUN);
    assign o_done       = (r_state == DONE);
    assign o_best_sad   = r_best_sad;
    assign o_best_row   = r_best_row;
    assign o_best_col   = r_best_col;

    assign w_accept = i_cand_valid && (r_state == RUN);
    assign w_begin  = i_start && ((r_state == IDLE) || (r_state == DONE));

    sad_compare_select #(.DATA_W(DATA_W)) u_cmp_sel (
        .i_cand_sad (i_cand_sad),
        .i_cand_row (i_cand_row),
        .i_cand_col (i_cand_col),
        .i_best_sad (r_best_sad),
        .i_best_row (r_best_row),
        .i_best_col (r_best_col),
        .o_next_sad (w_next_sad),
        .o_next_row (w_next_row),
        .o_next_col (w_next_col)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_accept && (r_count == LAST_IDX)) w_state_next = DONE;
            DONE:    if (i_start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_best_sad <= '1;
            r_best_row <= '0;
            r_best_col <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_begin) begin
                r_count    <= '0;
                r_best_sad <= '1;
                r_best_row <= '0;
                r_best_col <= '0;
            end else if (w_accept) begin
                r_count    <= r_count + 1'b1;
                r_best_sad <= w_next_sad;
                r_best_row <= w_next_row;
                r_best_col <= w_next_col;
            end
        end
    end
endmodule

// File: tb/tb_sad_min_tracker.sv
// Randomised scoreboard bench for sad_min_tracker with a four-candidate window.
module tb_sad_min_tracker;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] c_sad = '0, c_row = '0, c_col = '0;
    logic [31:0] b_sad, b_row, b_col;
    logic        busy, done;

    sad_min_tracker #(.DATA_W(32), .NUM_CAND(NC), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cand_valid(valid),
        .o_cand_ready(ready), .i_cand_sad(c_sad), .i_cand_row(c_row),
        .i_cand_col(c_col), .o_best_sad(b_sad), .o_best_row(b_row),
        .o_best_col(b_col), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sad;
        logic [31:0] row;
        logic [31:0] col;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: minimum SAD of the window, earliest position holding it;
    // an all-ones minimum never displaces the initial (all-ones, 0, 0).
    function automatic exp_t model(input logic [31:0] s[NC], input logic [31:0] r[NC],
                                   input logic [31:0] c[NC]);
        exp_t        e;
        logic [31:0] m;
        int          idx;
        m = 32'hFFFF_FFFF;
        foreach (s[i]) if (s[i] < m) m = s[i];
        e.sad = 32'hFFFF_FFFF; e.row = '0; e.col = '0; e.cyc = 0;
        if (m != 32'hFFFF_FFFF) begin
            idx = -1;
            for (int i = 0; i < NC; i++) if (idx < 0 && s[i] == m) idx = i;
            e.sad = s[idx]; e.row = r[idx]; e.col = c[idx];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("best_sad", b_sad, e.sad);
                chk("best_row", b_row, e.row);
                chk("best_col", b_col, e.col);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
        prev_done = done;
    end

    task automatic drive_window(input logic [31:0] s[NC], input logic [31:0] r[NC],
                                input logic [31:0] c[NC], input int gmin, input int gmax,
                                input bit start_mid);
        exp_t e;
        e = model(s, r, c);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_ready", {31'd0, ready}, 32'd1);
        chk("run_done", {31'd0, done}, 32'd0);
        chk("run_init_sad", b_sad, 32'hFFFF_FFFF);
        for (int k = 0; k < NC; k++) begin
            int gap;
            gap = $urandom_range(gmax, gmin);
            repeat (gap) @(negedge clk);
            valid = 1'b1; c_sad = s[k]; c_row = r[k]; c_col = c[k];
            if (start_mid && k == 2) start = 1'b1;
            if (k == NC - 1) begin
                e.cyc = cyc + 1;
                q.push_back(e);
                last_exp = e;
            end
            @(negedge clk);
            valid = 1'b0; start = 1'b0;
            c_sad = $urandom; c_row = $urandom; c_col = $urandom;
        end
        for (int t = 0; t < 10 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 32'd1, 32'd0);
            q.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sad"}, b_sad, 32'hFFFF_FFFF);
        chk({tag, "_row"}, b_row, 32'd0);
        chk({tag, "_col"}, b_col, 32'd0);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] s[NC], r[NC], c[NC];

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // Basic window with a tie on 20: the first one must win.
        s = '{50, 20, 30, 20}; r = '{0, 0, 1, 1}; c = '{0, 1, 0, 1};
        drive_window(s, r, c, 0, 0, 1'b0);

        // Same stream with 1-3 cycle gaps.
        drive_window(s, r, c, 1, 3, 1'b0);

        // Valid pulses in DONE are dropped.
        valid = 1'b1; c_sad = 32'd1; c_row = 32'd9; c_col = 32'd9;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        chk("done_hold_sad", b_sad, last_exp.sad);
        chk("done_hold_row", b_row, last_exp.row);
        chk("done_hold_col", b_col, last_exp.col);
        chk("done_hold_done", {31'd0, done}, 32'd1);

        // Mid-window reset after two accepts.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            valid = 1'b1; c_sad = 32'd3 + k; c_row = 32'd7; c_col = 32'd8;
            @(negedge clk);
        end
        valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        @(negedge clk); rst = 1'b0;

        // Valid pulses in IDLE are dropped.
        valid = 1'b1; c_sad = 32'd2; c_row = 32'd5; c_col = 32'd6;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        chk_reset_vals("idle_drop");

        // Clean window after abort, with a Start issued during RUN.
        s = '{5, 40, 60, 70}; r = '{11, 12, 13, 14}; c = '{21, 22, 23, 24};
        drive_window(s, r, c, 0, 1, 1'b1);

        // Back-to-back windows; second is entirely above the first best.
        s = '{100, 200, 90, 300}; r = '{1, 2, 3, 4}; c = '{5, 6, 7, 8};
        drive_window(s, r, c, 0, 0, 1'b0);
        s = '{150, 120, 500, 130}; r = '{31, 32, 33, 34}; c = '{41, 42, 43, 44};
        drive_window(s, r, c, 0, 0, 1'b0);

        // All-ones SADs never replace the initial value.
        s = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        r = '{1, 2, 3, 4}; c = '{5, 6, 7, 8};
        drive_window(s, r, c, 0, 2, 1'b0);

        // Random windows; small SAD range forces ties, occasional all-ones.
        for (int w = 0; w < 12; w++) begin
            for (int k = 0; k < NC; k++) begin
                s[k] = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(15, 0));
                r[k] = $urandom; c[k] = $urandom;
            end
            drive_window(s, r, c, 0, 2, ($urandom_range(3, 0) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
